// File: rtl/sram_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : sram_responder_if
// Description : Request/response handshake bundle between a load/store
//               requester and the sram_responder memory model.
// Revision    : 1.0 - initial release
// ============================================================================
interface sram_responder_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_wen;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [3:0]        req_wmask;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  // Requester side (core load/store port)
  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_wmask, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  // Responder side (memory)
  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_wmask, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/sram_responder.sv
`default_nettype none
// ============================================================================
// Module      : sram_responder
// Description : Single-outstanding byte-addressed SRAM responder with a
//               programmable access latency and valid/ready handshakes on
//               both the request and the response side.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_responder #(
  parameter int                ADDR_W     = 32,
  parameter int                DEPTH_LOG2 = 12,
  parameter logic [ADDR_W-1:0] BASE       = 32'h80000000,
  parameter int                LAT        = 2    // 1..15
) (
  input  wire logic         clk,
  input  wire logic         reset,   // asynchronous, active-low
  sram_responder_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Byte span covered by the array, one bit wider than the offset so the
  // comparison never overflows.
  localparam logic [ADDR_W:0] c_span =
    {{(ADDR_W-DEPTH_LOG2-2){1'b0}}, 1'b1, {(DEPTH_LOG2+2){1'b0}}};
  localparam logic [3:0] c_cnt_load = 4'(LAT - 1);

  state_t            r_state, w_state_nxt;
  logic [3:0]        r_cnt, w_cnt_nxt;
  logic              w_accept, w_commit;

  logic              r_wen;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_wmask;

  logic              r_req_ready;
  logic              r_rsp_valid;
  logic [31:0]       r_rsp_rdata;
  logic              r_rsp_err;

  logic [ADDR_W-1:0]     w_off;
  logic                  w_in_range;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic [1:0]            w_lane;
  logic [3:0]            w_lane_en;
  logic [31:0]           w_wdata_sh;
  logic [31:0]           w_rd_word;
  logic [31:0]           w_rd_sh;

  logic [31:0] r_mem [0:(1<<DEPTH_LOG2)-1];

  // Address decode of the captured request; offset wraps at ADDR_W bits so
  // addresses below BASE land far above the array and are rejected.
  assign w_off      = r_addr - BASE;
  assign w_in_range = ({1'b0, w_off} < c_span);
  assign w_idx      = w_off[DEPTH_LOG2+1:2];
  assign w_lane     = w_off[1:0];

  // Mask/data aligned to the word; mask bits past lane 3 fall off the top.
  assign w_lane_en  = r_wmask << w_lane;
  assign w_wdata_sh = r_wdata << {w_lane, 3'b000};
  assign w_rd_word  = r_mem[w_idx];
  assign w_rd_sh    = w_rd_word >> {w_lane, 3'b000};

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;

  // Next-state, latency countdown and event strobes
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.req_valid && r_req_ready) begin
          w_accept    = 1'b1;
          w_cnt_nxt   = c_cnt_load;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          w_commit    = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        if (r_rsp_valid && bus.rsp_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, request capture and registered response outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_wen       <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= 32'd0;
      r_wmask     <= 4'd0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_req_ready <= (w_state_nxt == IDLE);
      r_rsp_valid <= (w_state_nxt == RESP);
      if (w_accept) begin
        r_wen   <= bus.req_wen;
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
        r_wmask <= bus.req_wmask;
      end
      if (w_commit) begin
        r_rsp_err   <= ~w_in_range;
        r_rsp_rdata <= (w_in_range && !r_wen) ? w_rd_sh : 32'd0;
      end
    end
  end

  // Array write on the commit edge; only reachable from BUSY, so a reset
  // asserted before that edge drops the write.
  always_ff @(posedge clk) begin
    if (w_commit && r_wen && w_in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (w_lane_en[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_wdata_sh[8*i +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire
